// File: rtl/cbfp_pkg.sv
// Shared types and constants for the CBFP final-normalizer frame scheduler.
package cbfp_pkg;

  localparam int unsigned N_PTS  = 512;
  localparam int unsigned LANES  = 16;
  localparam int unsigned OUT_W  = 13;
  localparam int unsigned BEATS  = N_PTS / LANES;
  localparam int unsigned BEAT_W = $clog2(BEATS);
  localparam int unsigned LAT    = 2;
  localparam int unsigned WD_MAX = 8;
  localparam int unsigned WD_W   = $clog2(WD_MAX + 1);

  typedef logic signed [OUT_W-1:0] sample_t;

  typedef enum logic [1:0] {
    StIdle,
    StLaunch,
    StWait,
    StDrain
  } sched_state_e;

endpackage

// File: rtl/cbfp_norm_sched_if.sv
// Output beat stream of the normalizer scheduler: valid/ready with lane data.
interface cbfp_norm_sched_if
  import cbfp_pkg::*;
();

  logic                         out_valid;
  logic                         out_ready;
  sample_t [LANES-1:0]          out_re;
  sample_t [LANES-1:0]          out_im;
  logic    [BEAT_W-1:0]         out_beat;
  logic                         out_last;

  modport master (
    output out_valid, out_re, out_im, out_beat, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_re, out_im, out_beat, out_last,
    output out_ready
  );

endinterface

// File: rtl/cbfp_beat_mux.sv
// Registered N-to-LANES lane selector: on load, captures samples beat*LANES .. beat*LANES+LANES-1.
module cbfp_beat_mux #(
  parameter  int unsigned N     = 512,
  parameter  int unsigned LANES = 16,
  parameter  int unsigned W     = 13,
  localparam int unsigned BeatW = $clog2(N / LANES),
  localparam int unsigned LaneW = $clog2(LANES)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        load,
  input  logic [BeatW-1:0]            beat,
  input  logic [N-1:0][W-1:0]         in_re,
  input  logic [N-1:0][W-1:0]         in_im,
  output logic [LANES-1:0][W-1:0]     out_re,
  output logic [LANES-1:0][W-1:0]     out_im
);

  logic [LANES-1:0][W-1:0] nxt_re, nxt_im;

  // N and LANES are powers of two, so the sample index is just {beat, lane}.
  always_comb begin
    nxt_re = '0;
    nxt_im = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      nxt_re[k] = in_re[{beat, LaneW'(k)}];
      nxt_im[k] = in_im[{beat, LaneW'(k)}];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_re <= '0;
      out_im <= '0;
    end else if (load) begin
      out_re <= nxt_re;
      out_im <= nxt_im;
    end
  end

endmodule

// File: rtl/cbfp_norm_sched.sv
// Frame-level controller: launches the normalizer, watches for its result, then drains
// the 512 samples downstream in LANES-wide beats with backpressure.
module cbfp_norm_sched
  import cbfp_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  input  logic                  frm_valid_i,
  output logic                  frm_ready_o,
  output logic                  norm_valid_o,
  input  logic                  norm_done_i,
  input  sample_t [N_PTS-1:0]   norm_re_i,
  input  sample_t [N_PTS-1:0]   norm_im_i,
  cbfp_norm_sched_if.master     beat_if,
  output logic                  busy_o,
  output logic                  wd_err_o,
  output logic [15:0]           frame_cnt_o
);

  sched_state_e             state_q;
  logic                     frm_ready_q, norm_valid_q, out_valid_q, out_last_q, wd_err_q;
  logic [BEAT_W-1:0]        beat_q;
  logic [WD_W-1:0]          wd_q;
  logic [15:0]              frame_cnt_q;

  logic                     hs;
  logic                     mux_load;
  logic [BEAT_W-1:0]        mux_beat;
  logic [LANES-1:0][OUT_W-1:0] lane_re, lane_im;

  assign hs = out_valid_q && beat_if.out_ready;

  // Lanes for beat 0 are captured on norm_done; later beats load on each non-final handshake.
  always_comb begin
    mux_load = 1'b0;
    mux_beat = '0;
    if (!flush_i) begin
      if (state_q == StWait && norm_done_i) begin
        mux_load = 1'b1;
      end else if (state_q == StDrain && hs && !out_last_q) begin
        mux_load = 1'b1;
        mux_beat = beat_q + BEAT_W'(1);
      end
    end
  end

  cbfp_beat_mux #(
    .N     (N_PTS),
    .LANES (LANES),
    .W     (OUT_W)
  ) u_beat_mux (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (mux_load),
    .beat   (mux_beat),
    .in_re  (norm_re_i),
    .in_im  (norm_im_i),
    .out_re (lane_re),
    .out_im (lane_im)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      frm_ready_q  <= 1'b0;
      norm_valid_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      wd_err_q     <= 1'b0;
      beat_q       <= '0;
      wd_q         <= '0;
      frame_cnt_q  <= '0;
    end else if (flush_i) begin
      state_q      <= StIdle;
      frm_ready_q  <= 1'b1;
      norm_valid_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      wd_err_q     <= 1'b0;
      beat_q       <= '0;
    end else begin
      norm_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          frm_ready_q <= 1'b1;
          if (frm_valid_i && frm_ready_q) begin
            frm_ready_q  <= 1'b0;
            norm_valid_q <= 1'b1;
            wd_q         <= '0;
            state_q      <= StLaunch;
          end
        end
        StLaunch: begin
          wd_q    <= wd_q + WD_W'(1);
          state_q <= StWait;
        end
        // wd_q counts cycles since the launch pulse; the error lands WD_MAX cycles after it.
        StWait: begin
          if (norm_done_i) begin
            out_valid_q <= 1'b1;
            out_last_q  <= (BEATS == 1);
            beat_q      <= '0;
            state_q     <= StDrain;
          end else if (wd_q == WD_W'(WD_MAX - 1)) begin
            wd_err_q    <= 1'b1;
            frm_ready_q <= 1'b1;
            state_q     <= StIdle;
          end else begin
            wd_q <= wd_q + WD_W'(1);
          end
        end
        StDrain: begin
          if (hs) begin
            if (out_last_q) begin
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              frame_cnt_q <= frame_cnt_q + 16'd1;
              frm_ready_q <= 1'b1;
              state_q     <= StIdle;
            end else begin
              beat_q     <= beat_q + BEAT_W'(1);
              out_last_q <= (beat_q == BEAT_W'(BEATS - 2));
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign frm_ready_o       = frm_ready_q;
  assign norm_valid_o      = norm_valid_q;
  assign busy_o            = (state_q != StIdle);
  assign wd_err_o          = wd_err_q;
  assign frame_cnt_o       = frame_cnt_q;
  assign beat_if.out_valid = out_valid_q;
  assign beat_if.out_last  = out_last_q;
  assign beat_if.out_beat  = beat_q;
  assign beat_if.out_re    = lane_re;
  assign beat_if.out_im    = lane_im;

endmodule

// File: tb/tb_cbfp_norm_sched.sv
// Self-checking bench for cbfp_norm_sched: scoreboarded beats plus per-scenario timing checks.
module tb_cbfp_norm_sched;
  import cbfp_pkg::*;

  typedef struct packed {
    logic [BEAT_W-1:0]            beat;
    logic                         last;
    logic [LANES-1:0][OUT_W-1:0]  re;
    logic [LANES-1:0][OUT_W-1:0]  im;
  } beat_t;

  localparam logic [OUT_W-1:0] Pos83 = 13'd83;
  localparam logic [OUT_W-1:0] Neg83 = 13'h1fad;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic frm_valid = 1'b0;
  logic norm_done = 1'b0;
  logic frm_ready, norm_valid, busy, wd_err;
  logic [15:0] frame_cnt;
  logic [N_PTS-1:0][OUT_W-1:0] norm_re, norm_im;

  cbfp_norm_sched_if bus ();

  int    n_checks = 0;
  int    n_errors = 0;
  int    hs_cnt   = 0;
  int    data_off = 0;
  bit    done_en  = 1'b0;
  beat_t exp_q[$];
  beat_t held;
  bit    hold_vld = 1'b0;

  always #5 clk = ~clk;

  cbfp_norm_sched dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (flush),
    .frm_valid_i  (frm_valid),
    .frm_ready_o  (frm_ready),
    .norm_valid_o (norm_valid),
    .norm_done_i  (norm_done),
    .norm_re_i    (norm_re),
    .norm_im_i    (norm_im),
    .beat_if      (bus),
    .busy_o       (busy),
    .wd_err_o     (wd_err),
    .frame_cnt_o  (frame_cnt)
  );

  function automatic beat_t cur_beat();
    beat_t b;
    b.beat = bus.out_beat;
    b.last = bus.out_last;
    b.re   = bus.out_re;
    b.im   = bus.out_im;
    return b;
  endfunction

  function automatic logic [28:0] outs_vec();
    return {frm_ready, norm_valid, bus.out_valid, bus.out_last, busy, wd_err, frame_cnt,
            bus.out_beat, |bus.out_re, |bus.out_im};
  endfunction

  task automatic fill(input int off);
    for (int i = 0; i < N_PTS; i++) begin
      norm_re[i] = OUT_W'(i + off);
      norm_im[i] = OUT_W'(-(i + off));
    end
  endtask

  task automatic push_frame(input int off);
    beat_t e;
    for (int b = 0; b < BEATS; b++) begin
      e.beat = BEAT_W'(b);
      e.last = (b == BEATS - 1);
      for (int k = 0; k < LANES; k++) begin
        e.re[k] = OUT_W'(b * LANES + k + off);
        e.im[k] = OUT_W'(-(b * LANES + k + off));
      end
      exp_q.push_back(e);
    end
  endtask

  // Normalizer model: answers each launch pulse LAT cycles later and books the expected beats.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && norm_valid && done_en) begin
        repeat (LAT) @(posedge clk);
        #1;
        if (rst_n) begin
          norm_done = 1'b1;
          push_frame(data_off);
          @(posedge clk);
          #1 norm_done = 1'b0;
        end
      end
    end
  end

  // Downstream monitor: every handshake is checked against the scoreboard; stalls must hold data.
  always @(negedge clk) begin : mon
    beat_t got, e;
    if (!rst_n) begin
      hold_vld = 1'b0;
    end else if (bus.out_valid) begin
      got = cur_beat();
      if (hold_vld) begin
        n_checks++;
        if (got !== held) begin
          n_errors++;
          $display("FAIL stall_stable: got beat %0d re %h, held beat %0d re %h", got.beat,
                   got.re, held.beat, held.re);
        end
      end
      if (bus.out_ready) begin
        hs_cnt++;
        hold_vld = 1'b0;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL beat_unexpected: got beat %0d, required no beat", got.beat);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            n_errors++;
            $display("FAIL beat_data: got beat %0d last %b re %h im %h, required beat %0d last %b re %h im %h",
                     got.beat, got.last, got.re, got.im, e.beat, e.last, e.re, e.im);
          end
        end
      end else begin
        held     = got;
        hold_vld = 1'b1;
      end
    end else begin
      hold_vld = 1'b0;
    end
  end

  task automatic apply_reset();
    rst_n         = 1'b0;
    flush         = 1'b0;
    frm_valid     = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    exp_q.delete();
    #1 rst_n = 1'b1;
  endtask

  task automatic launch(output bit ok);
    ok        = 1'b0;
    frm_valid = 1'b1;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      if (frm_ready === 1'b1) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    frm_valid = 1'b0;
    if (!ok) begin
      n_checks++;
      n_errors++;
      $display("FAIL launch_timeout: frm_ready 0 for 100 cycles, required 1");
    end
  endtask

  task automatic drain(input int mode);
    bit fin = 1'b0;
    for (int c = 0; c < 400 && !fin; c++) begin
      bus.out_ready = (mode == 0) ? 1'b1 : (c % 3 == 0);
      @(negedge clk);
      if (!busy) fin = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    if (!fin) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain_timeout: busy 1 after 400 cycles, required 0");
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (outs_vec() !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: got %h, required 0", outs_vec());
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (frm_ready !== 1'b1 || busy !== 1'b0 || frame_cnt !== 16'd0) begin
      n_errors++;
      $display("FAIL reset_idle: got ready %b busy %b cnt %0d, required 1 0 0",
               frm_ready, busy, frame_cnt);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_frame();
    bit ok;
    logic [2:0] exp_ctl;
    done_en       = 1'b1;
    data_off      = 0;
    fill(0);
    bus.out_ready = 1'b1;
    launch(ok);
    for (int c = 0; c <= BEATS + 3; c++) begin
      @(negedge clk);
      exp_ctl = {c == 0, c >= 3 && c <= BEATS + 2, c == BEATS + 2};
      n_checks++;
      if ({norm_valid, bus.out_valid, bus.out_last} !== exp_ctl ||
          frm_ready !== (c == BEATS + 3)) begin
        n_errors++;
        $display("FAIL frame_timing c=%0d: got nv/ov/last %b ready %b, required %b ready %b",
                 c, {norm_valid, bus.out_valid, bus.out_last}, frm_ready, exp_ctl,
                 c == BEATS + 3);
      end
      if (c >= 3 && c <= BEATS + 2) begin
        n_checks++;
        if (bus.out_beat !== BEAT_W'(c - 3)) begin
          n_errors++;
          $display("FAIL beat_index c=%0d: got %0d, required %0d", c, bus.out_beat, c - 3);
        end
      end
      if (c == 8) begin
        n_checks++;
        if (bus.out_re[3] !== Pos83 || bus.out_im[3] !== Neg83) begin
          n_errors++;
          $display("FAIL beat5_lane3: got re %0d im %0d, required 83 -83",
                   $signed(bus.out_re[3]), $signed(bus.out_im[3]));
        end
      end
      if (c == BEATS + 3) begin
        n_checks++;
        if (frame_cnt !== 16'd1) begin
          n_errors++;
          $display("FAIL frame_cnt_single: got %0d, required 1", frame_cnt);
        end
      end
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL single_left: got %0d beats missing, required 0", exp_q.size());
    end
  endtask

  task automatic test_watchdog();
    bit ok;
    done_en       = 1'b0;
    bus.out_ready = 1'b1;
    launch(ok);
    for (int c = 0; c <= WD_MAX + 2; c++) begin
      @(negedge clk);
      n_checks++;
      if (wd_err !== (c >= WD_MAX) || bus.out_valid !== 1'b0 ||
          (c >= WD_MAX && busy !== 1'b0)) begin
        n_errors++;
        $display("FAIL watchdog c=%0d: got err %b valid %b busy %b, required err %b valid 0",
                 c, wd_err, bus.out_valid, busy, c >= WD_MAX);
      end
      @(posedge clk);
      #1;
    end
    flush = 1'b1;
    @(negedge clk);
    n_checks++;
    if (wd_err !== 1'b1) begin
      n_errors++;
      $display("FAIL wd_sticky: got %b, required 1", wd_err);
    end
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    n_checks++;
    if (wd_err !== 1'b0) begin
      n_errors++;
      $display("FAIL wd_flush_clear: got %b, required 0", wd_err);
    end
    @(posedge clk);
    #1 done_en = 1'b1;
  endtask

  task automatic test_flush();
    bit ok;
    bit hit = 1'b0;
    logic [15:0] start_cnt;
    start_cnt     = frame_cnt;
    done_en       = 1'b1;
    data_off      = 100;
    fill(100);
    bus.out_ready = 1'b1;
    launch(ok);
    for (int c = 0; c < 60 && !hit; c++) begin
      if (bus.out_valid && bus.out_beat == BEAT_W'(10)) begin
        hit           = 1'b1;
        flush         = 1'b1;
        bus.out_ready = 1'b0;
      end
      @(negedge clk);
      @(posedge clk);
      #1;
    end
    flush         = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (!hit || bus.out_valid !== 1'b0 || busy !== 1'b0 || frame_cnt !== start_cnt) begin
      n_errors++;
      $display("FAIL flush_abort: got hit %b valid %b busy %b cnt %0d, required 1 0 0 %0d",
               hit, bus.out_valid, busy, frame_cnt, start_cnt);
    end
    exp_q.delete();
    @(posedge clk);
    #1;
    data_off = 200;
    fill(200);
    launch(ok);
    drain(0);
    n_checks++;
    if (frame_cnt !== 16'(start_cnt + 1) || exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL flush_restart: got cnt %0d left %0d, required cnt %0d left 0",
               frame_cnt, exp_q.size(), start_cnt + 1);
    end
  endtask

  task automatic test_back_to_back();
    int last_p = -1;
    int np = 0;
    logic [15:0] start_cnt;
    start_cnt     = frame_cnt;
    done_en       = 1'b1;
    data_off      = 7;
    fill(7);
    bus.out_ready = 1'b1;
    frm_valid     = 1'b1;
    for (int c = 0; c < 250 && np < 4; c++) begin
      @(negedge clk);
      if (norm_valid === 1'b1) begin
        if (np > 0) begin
          n_checks++;
          if (c - last_p < 2 + LAT + BEATS) begin
            n_errors++;
            $display("FAIL pulse_spacing: got %0d cycles, required >= %0d", c - last_p,
                     2 + LAT + BEATS);
          end
        end
        last_p = c;
        np++;
      end
      @(posedge clk);
      #1;
    end
    frm_valid = 1'b0;
    drain(0);
    n_checks++;
    if (np != 4 || frame_cnt !== 16'(start_cnt + 4) || exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL back_to_back: got pulses %0d cnt %0d left %0d, required 4 %0d 0",
               np, frame_cnt, exp_q.size(), start_cnt + 4);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int hs0;
    apply_reset();
    done_en = 1'b1;
    for (int f = 0; f < 64; f++) begin
      data_off = f * 7;
      fill(f * 7);
      hs0 = hs_cnt;
      launch(ok);
      drain(1);
      n_checks++;
      if (hs_cnt - hs0 != BEATS) begin
        n_errors++;
        $display("FAIL bp_handshakes f=%0d: got %0d, required %0d", f, hs_cnt - hs0, BEATS);
      end
    end
    n_checks++;
    if (frame_cnt !== 16'd64 || exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL bp_frame_cnt: got %0d left %0d, required 64 left 0", frame_cnt,
               exp_q.size());
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    done_en       = 1'b0;
    bus.out_ready = 1'b1;
    launch(ok);
    @(posedge clk);
    #3;
    n_checks++;
    if (busy !== 1'b1) begin
      n_errors++;
      $display("FAIL wait_busy: got %b, required 1", busy);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (outs_vec() !== '0) begin
      n_errors++;
      $display("FAIL reset_mid_wait: got %h, required 0", outs_vec());
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    done_en  = 1'b1;
    data_off = 0;
    fill(0);
    launch(ok);
    repeat (10) @(posedge clk);
    #3;
    n_checks++;
    if (bus.out_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL drain_active: got valid %b, required 1", bus.out_valid);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (outs_vec() !== '0) begin
      n_errors++;
      $display("FAIL reset_mid_drain: got %h, required 0", outs_vec());
    end
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    data_off = 300;
    fill(300);
    launch(ok);
    drain(0);
    n_checks++;
    if (frame_cnt !== 16'd1 || exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL after_reset_frame: got cnt %0d left %0d, required 1 0", frame_cnt,
               exp_q.size());
    end
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "global timeout");
  end

  initial begin
    bus.out_ready = 1'b0;
    fill(0);
    test_reset();
    test_single_frame();
    test_watchdog();
    test_flush();
    test_back_to_back();
    test_backpressure();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
